// File: rtl/int_dot_mac_pipe.sv
// Pipelined integer dot-product accumulator: S1 multiplies and reduces one beat,
// S2 accumulates with saturation, and an output register holds one result per group.
`timescale 1ns/1ps
module int_dot_mac_pipe #(
  parameter int LANES = 32,
  parameter int DW    = 8,
  parameter int ACCW  = 24
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_first,
  input  logic                     in_last,
  input  logic                     in_signed,
  input  logic [(LANES+1)*DW-1:0]  a_vec,
  input  logic [(LANES+1)*DW-1:0]  b_vec,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ACCW-1:0]          out_sum,
  output logic [DW-1:0]            out_scale,
  output logic                     out_sat
);

  localparam int DOTW = 2*DW + $clog2(LANES) + 1;
  // Operands lie in [-2^(DW-1), 2^DW-1], so every product fits 2*DW+1 signed bits.
  localparam int PW   = 2*DW + 1;
  localparam int SW   = ACCW + 2;
  localparam logic signed [SW-1:0] SMAX = {3'b000, {(ACCW-1){1'b1}}};
  localparam logic signed [SW-1:0] SMIN = {3'b111, {(ACCW-1){1'b0}}};
  localparam logic signed [SW-1:0] UMAX = {2'b00, {ACCW{1'b1}}};

  logic                   advance;
  logic                   eff_signed;
  logic                   mode_reg;
  logic signed [PW-1:0]   prod [LANES];
  logic signed [DOTW-1:0] dot_next;

  logic                   s1_valid_reg, s1_first_reg, s1_last_reg, s1_signed_reg;
  logic [DW-1:0]          s1_scale_reg;
  logic signed [DOTW-1:0] s1_dot_reg;

  logic                   s2_valid_reg, s2_last_reg;
  logic [DW-1:0]          s2_scale_reg;
  logic [ACCW-1:0]        acc_reg;
  logic                   sat_reg;

  logic signed [SW-1:0]   base, sum;
  logic [ACCW-1:0]        acc_next;
  logic                   hit;
  logic                   unused_b0;

  assign advance    = !(out_valid && !out_ready);
  assign in_ready   = advance;
  assign eff_signed = in_first ? in_signed : mode_reg;
  assign unused_b0  = ^b_vec[DW-1:0];

  for (genvar gi = 1; gi <= LANES; gi++) begin : g_lane
    logic [DW-1:0] a_el, b_el;
    assign a_el = a_vec[gi*DW +: DW];
    assign b_el = b_vec[gi*DW +: DW];
    assign prod[gi-1] = $signed({{(PW-DW){eff_signed & a_el[DW-1]}}, a_el})
                      * $signed({{(PW-DW){eff_signed & b_el[DW-1]}}, b_el});
  end

  always_comb begin
    dot_next = '0;
    for (int i = 0; i < LANES; i++) begin
      dot_next = dot_next + DOTW'(prod[i]);
    end
  end

  always_comb begin
    base = '0;
    if (!s1_first_reg) begin
      if (s1_signed_reg) base = {{2{acc_reg[ACCW-1]}}, acc_reg};
      else               base = {2'b00, acc_reg};
    end
    sum      = base + SW'(s1_dot_reg);
    acc_next = sum[ACCW-1:0];
    hit      = 1'b0;
    if (s1_signed_reg) begin
      if (sum > SMAX) begin
        acc_next = SMAX[ACCW-1:0];
        hit      = 1'b1;
      end else if (sum < SMIN) begin
        acc_next = SMIN[ACCW-1:0];
        hit      = 1'b1;
      end
    end else begin
      if (sum > UMAX) begin
        acc_next = '1;
        hit      = 1'b1;
      end else if (sum[SW-1]) begin
        acc_next = '0;
        hit      = 1'b1;
      end
    end
  end

  // A stall freezes every stage at once, so nothing in flight can be overwritten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_reg      <= 1'b0;
      s1_valid_reg  <= 1'b0;
      s1_first_reg  <= 1'b0;
      s1_last_reg   <= 1'b0;
      s1_signed_reg <= 1'b0;
      s1_scale_reg  <= '0;
      s1_dot_reg    <= '0;
      s2_valid_reg  <= 1'b0;
      s2_last_reg   <= 1'b0;
      s2_scale_reg  <= '0;
      acc_reg       <= '0;
      sat_reg       <= 1'b0;
      out_valid     <= 1'b0;
      out_sum       <= '0;
      out_scale     <= '0;
      out_sat       <= 1'b0;
    end else if (advance) begin
      s1_valid_reg <= in_valid;
      if (in_valid) begin
        s1_first_reg  <= in_first;
        s1_last_reg   <= in_last;
        s1_signed_reg <= eff_signed;
        s1_scale_reg  <= a_vec[DW-1:0];
        s1_dot_reg    <= dot_next;
        if (in_first) mode_reg <= in_signed;
      end
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        acc_reg      <= acc_next;
        sat_reg      <= hit | (!s1_first_reg & sat_reg);
        s2_last_reg  <= s1_last_reg;
        s2_scale_reg <= s1_scale_reg;
      end
      if (s2_valid_reg && s2_last_reg) begin
        out_valid <= 1'b1;
        out_sum   <= acc_reg;
        out_scale <= s2_scale_reg;
        out_sat   <= sat_reg;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_int_dot_mac_pipe.sv
// Randomised and directed bench for int_dot_mac_pipe with an arithmetic group model
// and an output scoreboard.
`timescale 1ns/1ps
module tb_int_dot_mac_pipe;
  localparam int LANES = 32;
  localparam int DW    = 8;
  localparam int ACCW  = 24;
  localparam int VW    = (LANES+1)*DW;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0, in_first = 1'b0, in_last = 1'b0, in_signed = 1'b0;
  logic            out_ready = 1'b1;
  logic [VW-1:0]   a_vec = '0, b_vec = '0;
  logic            in_ready, out_valid, out_sat;
  logic [ACCW-1:0] out_sum;
  logic [DW-1:0]   out_scale;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [ACCW-1:0] sum;
    logic [DW-1:0]   scale;
    logic            sat;
  } res_t;
  res_t exp_q[$];

  bit     m_signed = 0;
  longint m_acc    = 0;
  bit     m_sat    = 0;
  bit     rdone;

  int_dot_mac_pipe #(.LANES(LANES), .DW(DW), .ACCW(ACCW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_first(in_first), .in_last(in_last), .in_signed(in_signed),
    .a_vec(a_vec), .b_vec(b_vec),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_scale(out_scale), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  function automatic longint elem(input logic [VW-1:0] v, input int j, input bit sg);
    logic [DW-1:0] e;
    e = v[j*DW +: DW];
    return sg ? longint'($signed(e)) : longint'(e);
  endfunction

  function automatic logic [VW-1:0] fill(input logic [DW-1:0] scale, input logic [DW-1:0] v);
    logic [VW-1:0] r;
    for (int j = 1; j <= LANES; j++) r[j*DW +: DW] = v;
    r[DW-1:0] = scale;
    return r;
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] r;
    for (int j = 0; j <= LANES; j++) r[j*DW +: DW] = DW'($urandom);
    return r;
  endfunction

  // Reference: dot product of lanes 1..LANES, then clamped group accumulation.
  task automatic model_beat(input bit first, input bit last, input bit sg,
                            input logic [VW-1:0] a, input logic [VW-1:0] b);
    longint dot, s, hi, lo;
    bit hitm;
    res_t r;
    if (first) m_signed = sg;
    dot = 0;
    for (int j = 1; j <= LANES; j++) dot += elem(a, j, m_signed) * elem(b, j, m_signed);
    s = (first ? 0 : m_acc) + dot;
    if (m_signed) begin
      hi = (longint'(1) << (ACCW-1)) - 1;
      lo = -(longint'(1) << (ACCW-1));
    end else begin
      hi = (longint'(1) << ACCW) - 1;
      lo = 0;
    end
    hitm = (s > hi) || (s < lo);
    if (s > hi) s = hi;
    if (s < lo) s = lo;
    m_acc = s;
    m_sat = first ? hitm : (m_sat | hitm);
    if (last) begin
      r.sum   = s[ACCW-1:0];
      r.scale = a[DW-1:0];
      r.sat   = m_sat;
      exp_q.push_back(r);
    end
  endtask

  // Called at a rising edge; returns at the edge that accepted the beat.
  task automatic send(input bit first, input bit last, input bit sg,
                      input logic [VW-1:0] a, input logic [VW-1:0] b);
    int waits;
    #2;
    in_valid = 1'b1; in_first = first; in_last = last; in_signed = sg;
    a_vec = a; b_vec = b;
    waits = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waits++;
      if (waits > 100) begin
        total++; bad++;
        $display("FAIL accept_timeout in_ready=%0b required=1", in_ready);
        in_valid = 1'b0;
        @(posedge clk);
        return;
      end
    end
    @(posedge clk);
    model_beat(first, last, sg, a, b);
  endtask

  task automatic idle(input int n);
    #2;
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  task automatic wait_out(output bit ok);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL out_valid_timeout out_valid=%0b required=1", out_valid);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_acc = 0; m_signed = 0; m_sat = 0;
  endtask

  task automatic monitor();
    bit stall_prev = 0;
    logic [ACCW-1:0] held_sum;
    logic [DW-1:0]   held_scale;
    logic            held_sat;
    res_t r;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        if (!out_ready) begin
          if (stall_prev) begin
            total++;
            if ({out_sum, out_scale, out_sat} !== {held_sum, held_scale, held_sat}) begin
              bad++;
              $display("FAIL stall_hold sum=%h scale=%h sat=%0b required sum=%h scale=%h sat=%0b",
                       out_sum, out_scale, out_sat, held_sum, held_scale, held_sat);
            end
          end
          stall_prev = 1;
          held_sum = out_sum; held_scale = out_scale; held_sat = out_sat;
        end else begin
          stall_prev = 0;
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_result sum=%h required none", out_sum);
          end else begin
            r = exp_q.pop_front();
            if (out_sum !== r.sum || out_scale !== r.scale || out_sat !== r.sat) begin
              bad++;
              $display("FAIL result sum=%h scale=%h sat=%0b required sum=%h scale=%h sat=%0b",
                       out_sum, out_scale, out_sat, r.sum, r.scale, r.sat);
            end else begin
              $display("result ok sum=%h scale=%h sat=%0b", out_sum, out_scale, out_sat);
            end
          end
        end
      end else begin
        stall_prev = 0;
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) break;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    @(posedge clk);
  endtask

  task automatic test_reset();
    #3;
    total++;
    if ({out_valid, out_sum, out_scale, out_sat, in_ready} !== {1'b0, {ACCW{1'b0}}, {DW{1'b0}}, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL reset_state valid=%0b sum=%h scale=%h sat=%0b in_ready=%0b required 0/0/0/0/1",
               out_valid, out_sum, out_scale, out_sat, in_ready);
    end
    @(posedge clk); #2; rst_n = 1'b1;
    @(posedge clk);
  endtask

  task automatic test_unsigned_single();
    idle(4);
    send(1, 1, 0, fill(8'h05, 8'd1), fill(8'h00, 8'd2));
    #2; in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL latency_early1 out_valid=%0b required=0", out_valid);
    end
    @(posedge clk); @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL latency_early2 out_valid=%0b required=0", out_valid);
    end
    @(posedge clk); @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || out_sum !== 24'd64 || out_scale !== 8'h05 || out_sat !== 1'b0) begin
      bad++;
      $display("FAIL unsigned_single valid=%0b sum=%0d scale=%h sat=%0b required 1/64/05/0",
               out_valid, out_sum, out_scale, out_sat);
    end
    @(posedge clk);
  endtask

  task automatic test_signed_single();
    bit ok;
    idle(2);
    send(1, 1, 1, fill(8'h09, 8'hFF), fill(8'h00, 8'd3));
    idle(0);
    wait_out(ok);
    if (ok) begin
      total++;
      if (out_sum !== 24'hFFFFA0 || out_sat !== 1'b0) begin
        bad++; $display("FAIL signed_single sum=%h sat=%0b required FFFFA0/0", out_sum, out_sat);
      end
    end
    @(posedge clk);
  endtask

  task automatic test_unsigned_sat();
    bit ok;
    idle(2);
    for (int i = 0; i < 9; i++) send(i == 0, i == 8, 0, fill(8'h11, 8'hFF), fill(8'h00, 8'hFF));
    idle(0);
    wait_out(ok);
    if (ok) begin
      total++;
      if (out_sum !== 24'hFFFFFF || out_sat !== 1'b1) begin
        bad++; $display("FAIL unsigned_sat sum=%h sat=%0b required FFFFFF/1", out_sum, out_sat);
      end
    end
    @(posedge clk);
    for (int i = 0; i < 4; i++) send(i == 0, i == 3, 0, fill(8'h12, 8'hFF), fill(8'h00, 8'hFF));
    idle(0);
    wait_out(ok);
    if (ok) begin
      total++;
      if (out_sum !== 24'd8323200 || out_sat !== 1'b0) begin
        bad++; $display("FAIL unsigned_after_sat sum=%0d sat=%0b required 8323200/0", out_sum, out_sat);
      end
    end
    @(posedge clk);
  endtask

  task automatic test_signed_sat();
    bit ok;
    idle(2);
    for (int i = 0; i < 16; i++) send(i == 0, i == 15, 1, fill(8'h21, 8'h80), fill(8'h00, 8'h80));
    idle(0);
    wait_out(ok);
    if (ok) begin
      total++;
      if (out_sum !== 24'h7FFFFF || out_sat !== 1'b1) begin
        bad++; $display("FAIL signed_sat16 sum=%h sat=%0b required 7FFFFF/1", out_sum, out_sat);
      end
    end
    @(posedge clk);
    for (int i = 0; i < 15; i++) send(i == 0, i == 14, 1, fill(8'h22, 8'h80), fill(8'h00, 8'h80));
    idle(0);
    wait_out(ok);
    if (ok) begin
      total++;
      if (out_sum !== 24'h780000 || out_sat !== 1'b0) begin
        bad++; $display("FAIL signed_sat15 sum=%h sat=%0b required 780000/0", out_sum, out_sat);
      end
    end
    @(posedge clk);
  endtask

  task automatic test_backpressure();
    idle(2);
    fork
      begin
        for (int g = 0; g < 6; g++) send(1, 1, 1'($urandom), rand_vec(), rand_vec());
        idle(1);
      end
      begin
        logic [ACCW-1:0] held;
        bit seen;
        #2; out_ready = 1'b0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
          @(negedge clk);
          if (out_valid) seen = 1;
        end
        total++;
        if (!seen) begin
          bad++; $display("FAIL bp_valid out_valid=%0b required=1", out_valid);
        end
        held = out_sum;
        repeat (5) begin
          @(negedge clk);
          total++;
          if (in_ready !== 1'b0 || out_sum !== held) begin
            bad++;
            $display("FAIL bp_stall in_ready=%0b sum=%h required 0/%h", in_ready, out_sum, held);
          end
        end
        @(posedge clk); #2; out_ready = 1'b1;
      end
    join
    @(posedge clk);
    drain();
  endtask

  task automatic test_reset_mid_group();
    bit ok;
    idle(2);
    #2; out_ready = 1'b0;
    @(posedge clk);
    send(1, 1, 0, rand_vec(), rand_vec());
    send(1, 0, 0, rand_vec(), rand_vec());
    send(0, 0, 0, rand_vec(), rand_vec());
    #2; in_valid = 1'b0;
    @(posedge clk);
    #2; rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_mid out_valid=%0b in_ready=%0b required 0/1", out_valid, in_ready);
    end
    out_ready = 1'b1;
    @(posedge clk); @(posedge clk); #2; rst_n = 1'b1;
    @(posedge clk);
    send(1, 1, 0, fill(8'h33, 8'd1), fill(8'h00, 8'd1));
    idle(0);
    wait_out(ok);
    if (ok) begin
      total++;
      if (out_sum !== 24'd32 || out_scale !== 8'h33) begin
        bad++; $display("FAIL after_reset sum=%0d scale=%h required 32/33", out_sum, out_scale);
      end
    end
    @(posedge clk);
  endtask

  task automatic test_prefirst();
    bit ok;
    idle(2);
    #2; rst_n = 1'b0;
    model_reset();
    @(posedge clk); #2; rst_n = 1'b1;
    @(posedge clk);
    send(0, 0, 1, fill(8'h44, 8'd1), fill(8'h00, 8'd1));
    send(0, 1, 1, fill(8'h45, 8'd1), fill(8'h00, 8'd2));
    idle(0);
    wait_out(ok);
    if (ok) begin
      total++;
      if (out_sum !== 24'd96 || out_scale !== 8'h45 || out_sat !== 1'b0) begin
        bad++; $display("FAIL prefirst sum=%0d scale=%h sat=%0b required 96/45/0", out_sum, out_scale, out_sat);
      end
    end
    @(posedge clk);
  endtask

  task automatic test_random();
    idle(2);
    rdone = 0;
    fork
      begin
        for (int g = 0; g < 40; g++) begin
          int len;
          bit sg;
          len = $urandom_range(1, 5);
          sg  = 1'($urandom);
          for (int i = 0; i < len; i++) begin
            logic [VW-1:0] a, b;
            int p;
            p = $urandom_range(0, 3);
            a = (p == 1) ? fill(8'($urandom), 8'hFF) : (p == 2) ? fill(8'($urandom), 8'h80) : rand_vec();
            b = (p == 1) ? fill(8'h00, 8'hFF) : (p == 2) ? fill(8'h00, 8'h80) : rand_vec();
            send(i == 0, i == len-1, (i == 0) ? sg : 1'($urandom), a, b);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
          end
        end
        idle(1);
        rdone = 1;
      end
      begin
        while (!rdone) begin
          @(posedge clk); #2;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    @(posedge clk);
    drain();
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_unsigned_single();
    test_signed_single();
    test_unsigned_sat();
    test_signed_sat();
    test_backpressure();
    test_reset_mid_group();
    test_prefirst();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
